// File: rtl/clkgen_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM states, default timing
// constants and small arithmetic helpers.
package clkgen_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SW_RST    = 3'd4
  } state_e;

  localparam int DEF_NUM_DOMAINS    = 3;
  localparam int DEF_PLL_RST_CYCLES = 8;
  localparam int DEF_STAGGER        = 16;
  localparam int DEF_LOCK_TIMEOUT   = 1024;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Saturating 4-bit increment used for the retry counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'h1;
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to 0.
module bit_sync2 (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Capture and re-register the asynchronous input.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL reset / lock supervision with staggered per-domain reset release,
// software-requested re-sequencing and sticky lock-loss reporting.
module pll_rst_sequencer
  import clkgen_pkg::*;
#(
  parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int STAGGER        = DEF_STAGGER,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   pll_locked,
  input  logic                   sw_rst_req,
  input  logic                   lock_lost_clr,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic                   lock_lost,
  output logic [3:0]             retry_cnt
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, NUM_DOMAINS * STAGGER + 1) + 1);
  localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(NUM_DOMAINS * STAGGER);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(STAGGER - 1);

  state_e                 state_r, state_nx_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nx_s;
  logic                   locked_s;
  logic                   loss_s;
  logic                   retry_inc_s;
  logic                   pll_rst_r, ready_r, lock_lost_r;
  logic [NUM_DOMAINS-1:0] rst_out_r, rst_out_nx_s;
  logic [3:0]             retry_r;

  bit_sync2 u_lock_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      (pll_locked),
    .q      (locked_s)
  );

  // Next-state and shared counter; lock loss overrides every other transition.
  always_comb begin
    state_nx_s  = state_r;
    loss_s      = 1'b0;
    retry_inc_s = 1'b0;
    case (state_r)
      PLL_RST: begin
        if (cnt_r == PLL_LAST) state_nx_s = WAIT_LOCK;
        else                   state_nx_s = PLL_RST;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nx_s = RELEASE;
        end else if (cnt_r == TO_LAST) begin
          state_nx_s  = PLL_RST;
          retry_inc_s = 1'b1;
        end else begin
          state_nx_s = WAIT_LOCK;
        end
      end
      RELEASE: begin
        if (!locked_s)              loss_s     = 1'b1;
        else if (cnt_r == REL_LAST) state_nx_s = RUN;
        else                        state_nx_s = RELEASE;
      end
      RUN: begin
        if (!locked_s)       loss_s     = 1'b1;
        else if (sw_rst_req) state_nx_s = SW_RST;
        else                 state_nx_s = RUN;
      end
      SW_RST: begin
        if (!locked_s)             loss_s     = 1'b1;
        else if (cnt_r == SW_LAST) state_nx_s = RELEASE;
        else                       state_nx_s = SW_RST;
      end
      default: state_nx_s = PLL_RST;
    endcase
    if (loss_s) state_nx_s = PLL_RST;
    else        state_nx_s = state_nx_s;
    if (state_nx_s != state_r) cnt_nx_s = '0;
    else if (state_r == RUN)   cnt_nx_s = cnt_r;
    else                       cnt_nx_s = cnt_r + CNT_W'(1);
  end

  // Domain resets are decoded from the next state so they register in step with it.
  always_comb begin
    rst_out_nx_s = '1;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (state_nx_s == RELEASE)  rst_out_nx_s[i] = (cnt_nx_s < CNT_W'((i + 1) * STAGGER));
      else if (state_nx_s == RUN) rst_out_nx_s[i] = 1'b0;
      else                        rst_out_nx_s[i] = 1'b1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r     <= PLL_RST;
      cnt_r       <= '0;
      pll_rst_r   <= 1'b1;
      rst_out_r   <= '1;
      ready_r     <= 1'b0;
      lock_lost_r <= 1'b0;
      retry_r     <= 4'h0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      pll_rst_r   <= (state_nx_s == PLL_RST);
      rst_out_r   <= rst_out_nx_s;
      ready_r     <= (state_nx_s == RUN);
      lock_lost_r <= loss_s | (lock_lost_r & ~lock_lost_clr);
      retry_r     <= retry_inc_s ? sat_inc4(retry_r) : retry_r;
    end
  end

  assign pll_rst   = pll_rst_r;
  assign rst_out   = rst_out_r;
  assign ready     = ready_r;
  assign lock_lost = lock_lost_r;
  assign retry_cnt = retry_r;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Directed bench for pll_rst_sequencer at default parameters; expected cycle
// positions are hand-derived from the last reset edge / lock input changes.
module tb_pll_rst_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       lock_lost_clr = 1'b0;
  logic       pll_rst;
  logic [2:0] rst_out;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base, r, t, s, u, p;

  pll_rst_sequencer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .pll_locked    (pll_locked),
    .sw_rst_req    (sw_rst_req),
    .lock_lost_clr (lock_lost_clr),
    .pll_rst       (pll_rst),
    .rst_out       (rst_out),
    .ready         (ready),
    .lock_lost     (lock_lost),
    .retry_cnt     (retry_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic go(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    // Reset, then lock at cycle 20 and staggered release.
    tick(); tick();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_rst_out", rst_out, 3'b111);
    chk("rst_ready", ready, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_retry", retry_cnt, 0);
    rst_in = 1'b0;
    base = cyc;
    go(base + 7);  chk("pll_rst_hold", pll_rst, 1);
    go(base + 8);  chk("pll_rst_fall", pll_rst, 0);
    go(base + 20); pll_locked = 1'b1;
    r = base + 23;
    go(r + 15); chk("rel_d0_hold", rst_out, 3'b111);
    go(r + 16); chk("rel_d0_fall", rst_out, 3'b110);
    go(r + 31); chk("rel_d1_hold", rst_out, 3'b110);
    go(r + 32); chk("rel_d1_fall", rst_out, 3'b100);
    go(r + 47); chk("rel_d2_hold", rst_out, 3'b100);
    go(r + 48); chk("rel_d2_fall", rst_out, 3'b000);
    chk("ready_pre", ready, 0);
    go(r + 49); chk("ready_run", ready, 1);

    // One-cycle lock drop in RUN.
    t = r + 54;
    go(t); pll_locked = 1'b0;
    tick(); pll_locked = 1'b1;
    go(t + 2); chk("loss_ready_still", ready, 1);
    go(t + 3);
    chk("loss_rst_out", rst_out, 3'b111);
    chk("loss_ready", ready, 0);
    chk("loss_flag", lock_lost, 1);
    chk("loss_pll_rst", pll_rst, 1);
    go(t + 10); chk("loss_pll_rst_hold", pll_rst, 1);
    go(t + 11); chk("loss_pll_rst_fall", pll_rst, 0);
    go(t + 14); chk("loss_flag_sticky", lock_lost, 1);
    lock_lost_clr = 1'b1;
    tick(); lock_lost_clr = 1'b0;
    chk("loss_flag_clr", lock_lost, 0);
    go(t + 12 + 48); chk("rerun_rst_out", rst_out, 3'b000);
    go(t + 12 + 49); chk("rerun_ready", ready, 1);

    // Software reset in RUN; a request during RELEASE is ignored.
    s = t + 12 + 54;
    go(s); sw_rst_req = 1'b1;
    tick(); sw_rst_req = 1'b0;
    chk("sw_ready", ready, 0);
    chk("sw_rst_out", rst_out, 3'b111);
    chk("sw_pll_rst", pll_rst, 0);
    go(s + 10); chk("sw_pll_rst_mid", pll_rst, 0);
    go(s + 20); sw_rst_req = 1'b1;
    tick(); sw_rst_req = 1'b0;
    go(s + 32); chk("sw_rel_hold", rst_out, 3'b111);
    go(s + 33); chk("sw_rel_d0", rst_out, 3'b110);
    go(s + 49); chk("sw_rel_d1", rst_out, 3'b100);
    go(s + 65); chk("sw_rel_d2", rst_out, 3'b000);
    chk("sw_ready_pre", ready, 0);
    go(s + 66); chk("sw_ready_run", ready, 1);

    // Lock loss, sw request and lock_lost_clr in the same cycle.
    u = s + 71;
    go(u); pll_locked = 1'b0;
    tick(); pll_locked = 1'b1;
    go(u + 2); sw_rst_req = 1'b1; lock_lost_clr = 1'b1;
    tick(); sw_rst_req = 1'b0; lock_lost_clr = 1'b0;
    chk("both_pll_rst", pll_rst, 1);
    chk("both_flag", lock_lost, 1);
    chk("both_rst_out", rst_out, 3'b111);
    go(u + 10); chk("both_pll_rst_hold", pll_rst, 1);

    // Reset asserted during RELEASE.
    go(u + 12 + 20);
    chk("mid_rel", rst_out, 3'b110);
    rst_in = 1'b1;
    tick();
    chk("mid_rst_pll_rst", pll_rst, 1);
    chk("mid_rst_rst_out", rst_out, 3'b111);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_flag", lock_lost, 0);
    pll_locked = 1'b0;
    tick(); rst_in = 1'b0;
    base = cyc;

    // Lock never arrives: retries every 1032 cycles, saturating at 15.
    go(base + 7);    chk("re_pll_rst_hold", pll_rst, 1);
    go(base + 8);    chk("re_pll_rst_fall", pll_rst, 0);
    go(base + 1031); chk("to_retry0", retry_cnt, 0);
    chk("to_wait_pll_rst", pll_rst, 0);
    go(base + 1032); chk("to_retry1", retry_cnt, 1);
    chk("to_pll_rst", pll_rst, 1);
    go(base + 14 * 1032); chk("to_retry14", retry_cnt, 14);
    go(base + 15 * 1032); chk("to_retry15", retry_cnt, 15);
    go(base + 16 * 1032); chk("to_retry_sat", retry_cnt, 15);
    chk("to_pll_rst16", pll_rst, 1);

    // Lock after saturation, then reset clears the retry count.
    p = cyc;
    pll_locked = 1'b1;
    go(p + 24); chk("late_rel_hold", rst_out, 3'b111);
    go(p + 25); chk("late_rel_d0", rst_out, 3'b110);
    rst_in = 1'b1;
    tick();
    chk("final_retry", retry_cnt, 0);
    chk("final_rst_out", rst_out, 3'b111);
    chk("final_pll_rst", pll_rst, 1);
    rst_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_rst_sequencer.md
PLL_RST_SEQUENCER -- requirements
Module: pll_rst_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 3: number of sequenced downstream reset outputs (1..8).
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 8: cycles pll_rst is held high per PLL reset attempt.
REQ-003 SHALL have parameter STAGGER, default 16: cycles between successive domain reset releases.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 1024: cycles allowed in WAIT_LOCK before retry.
REQ-005 SHALL have port clk_in  input  1: single clock for all logic.
REQ-006 SHALL have port rst_in  input  1: synchronous, active-high reset.
REQ-007 SHALL have port pll_locked  input  1: PLL lock indication, asynchronous to clk_in.
REQ-008 SHALL have port sw_rst_req  input  1: single-cycle software request to re-run the domain reset sequence.
REQ-009 SHALL have port lock_lost_clr  input  1: clears the lock_lost status.
REQ-010 SHALL have port pll_rst  output  1: active-high reset driven to the PLL.
REQ-011 SHALL have port rst_out  output  NUM_DOMAINS: active-high per-domain resets; bit 0 releases first.
REQ-012 SHALL have port ready  output  1: high only in RUN.
REQ-013 SHALL have port lock_lost  output  1: sticky flag, set when lock drops after first lock.
REQ-014 SHALL have port retry_cnt  output  4: saturating count of lock timeouts.

Function
REQ-015 SHALL pass pll_locked through a 2-flop synchronizer (locked_s); the FSM acts on locked_s only, 2 cycles after the input changes.
REQ-016 SHALL implement FSM states PLL_RST, WAIT_LOCK, RELEASE, RUN, SW_RST, with one shared cycle counter cleared on every state entry.
REQ-017 PLL_RST: pll_rst=1, all rst_out=1; after PLL_RST_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0, all rst_out=1; locked_s=1 -> RELEASE; counter reaching LOCK_TIMEOUT-1 with locked_s=0 -> PLL_RST and retry_cnt+1, saturating at 15.
REQ-019 RELEASE: rst_out[i] SHALL deassert on cycle (i+1)*STAGGER after entry and remain low; the cycle after rst_out[NUM_DOMAINS-1] deasserts -> RUN.
REQ-020 RUN: ready=1, all rst_out=0.
REQ-021 locked_s=0 in RELEASE or RUN SHALL re-assert all rst_out, drop ready on the next cycle, -> PLL_RST and set lock_lost.
REQ-022 sw_rst_req in RUN -> SW_RST: all rst_out=1 and ready=0 for STAGGER cycles, then RELEASE; pll_rst stays 0.
REQ-023 sw_rst_req outside RUN SHALL be ignored (not queued).
REQ-024 Simultaneous lock loss and sw_rst_req SHALL follow lock loss (REQ-021).
REQ-025 lock_lost SHALL clear on lock_lost_clr; a simultaneous new lock loss SHALL win (stays set).
REQ-026 Lock loss in SW_RST SHALL -> PLL_RST and set lock_lost.
REQ-027 All outputs SHALL be registered; no output may glitch combinationally.

Reset
REQ-028 On rst_in=1 at a clk_in edge: state=PLL_RST, counter=0, synchronizer flops=0, pll_rst=1, rst_out all 1, ready=0, lock_lost=0, retry_cnt=0.
REQ-029 rst_in asserted mid-sequence SHALL abort immediately, with the full sequence restarting from PLL_RST after release.

Structure
REQ-030 A shared package clkgen_pkg SHALL hold the FSM state enumeration and the default parameter constants.
REQ-031 The synchronizer SHALL be a sub-module bit_sync2 (2 flops, reset value 0); the rest is flat.

Verification
REQ-032 Reset, then pll_locked=1 at cycle 20 -> pll_rst falls at cycle 8; rst_out[0/1/2] fall at 16/32/48 cycles after RELEASE entry; ready=1 one cycle after rst_out[2].
REQ-033 pll_locked held 0 -> PLL_RST re-entered every 8+1024 cycles, retry_cnt increments, saturates at 15 after 15 timeouts.
REQ-034 In RUN, drop pll_locked for 1 cycle -> within 4 cycles all rst_out=1, ready=0, lock_lost=1, pll_rst=1 for 8 cycles; lock_lost_clr pulse -> lock_lost=0.
REQ-035 In RUN, sw_rst_req pulse -> rst_out=3'b111 for 16 cycles, pll_rst stays 0, then staggered release as in REQ-032.
REQ-036 sw_rst_req and lock loss in same cycle, and rst_in during RELEASE -> lock-loss path taken; reset restores REQ-028 values.
